net_iso_recovery_ctrl: RTL and testbench

NET_ISO_RECOVERY_CTRL -- requirements
Module: net_iso_recovery_ctrl

---
 rtl/net_iso_recovery_ctrl.sv | 141 ++++++++++++++
 tb/tb_net_iso_recovery_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_iso_recovery_ctrl.sv
// Network isolation recovery controller: decouples the datapath on egress/ingress
// errors, pulses the error clears, dwells, then releases and counts recoveries.
module net_iso_recovery_ctrl #(
    parameter int HOLDOFF_WIDTH = 16,
    parameter int DONE_TIMEOUT  = 1024
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     sw_decouple,
    input  logic                     auto_recover_en,
    input  logic                     oversize_error_irq,
    input  logic                     timeout_error_irq,
    input  logic                     decouple_done,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles,
    input  logic                     fault_clear,
    output logic                     decouple,
    output logic                     oversize_error_clear,
    output logic                     timeout_error_clear,
    output logic                     recovery_active,
    output logic                     done_timeout_err,
    output logic [15:0]              recovery_count,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECOUPLE = 3'd1,
        CLEAR    = 3'd2,
        HOLDOFF  = 3'd3,
        RELEASE  = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam int CNT_W = (HOLDOFF_WIDTH > 16) ? HOLDOFF_WIDTH : 16;
    // Last wait-counter value before giving up on the decoupler handshake.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DONE_TIMEOUT - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_lat_q, err_lat_d;
    logic             done_err_d;
    logic             count_inc;
    logic             any_irq;

    assign any_irq = oversize_error_irq | timeout_error_irq;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_lat_d  = err_lat_q;
        done_err_d = done_timeout_err;
        count_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (auto_recover_en && any_irq) begin
                    err_lat_d = {timeout_error_irq, oversize_error_irq};
                    state_d   = DECOUPLE;
                end
            end
            DECOUPLE: begin
                if (decouple_done) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = FAULT;
                    done_err_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEAR: begin
                state_d = HOLDOFF;
                cnt_d   = CNT_W'(holdoff_cycles);
            end
            HOLDOFF: begin
                // A zero or one load both make this the final dwell cycle.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d = '0;
                    if (any_irq) begin
                        err_lat_d = {timeout_error_irq, oversize_error_irq};
                        state_d   = CLEAR;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (sw_decouple || !decouple_done) begin
                    state_d   = IDLE;
                    count_inc = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = FAULT;
                    done_err_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_d    = IDLE;
                    done_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q              <= IDLE;
            cnt_q                <= '0;
            err_lat_q            <= '0;
            decouple             <= 1'b0;
            oversize_error_clear <= 1'b0;
            timeout_error_clear  <= 1'b0;
            done_timeout_err     <= 1'b0;
            recovery_count       <= '0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            err_lat_q            <= err_lat_d;
            decouple             <= sw_decouple |
                                    (state_d inside {DECOUPLE, CLEAR, HOLDOFF, FAULT});
            oversize_error_clear <= (state_d == CLEAR) & err_lat_d[0];
            timeout_error_clear  <= (state_d == CLEAR) & err_lat_d[1];
            done_timeout_err     <= done_err_d;
            if (count_inc && (recovery_count != 16'hFFFF))
                recovery_count <= recovery_count + 16'd1;
        end
    end

    assign fsm_state       = state_q;
    assign recovery_active = (state_q != IDLE);

endmodule

// File: tb/tb_net_iso_recovery_ctrl.sv
// Directed bench for net_iso_recovery_ctrl with DONE_TIMEOUT shortened to 16.
module tb_net_iso_recovery_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        sw_decouple;
    logic        auto_recover_en;
    logic        oversize_error_irq;
    logic        timeout_error_irq;
    logic        decouple_done;
    logic [15:0] holdoff_cycles;
    logic        fault_clear;
    logic        decouple;
    logic        oversize_error_clear;
    logic        timeout_error_clear;
    logic        recovery_active;
    logic        done_timeout_err;
    logic [15:0] recovery_count;
    logic [2:0]  fsm_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    net_iso_recovery_ctrl #(.HOLDOFF_WIDTH(16), .DONE_TIMEOUT(16)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .sw_decouple          (sw_decouple),
        .auto_recover_en      (auto_recover_en),
        .oversize_error_irq   (oversize_error_irq),
        .timeout_error_irq    (timeout_error_irq),
        .decouple_done        (decouple_done),
        .holdoff_cycles       (holdoff_cycles),
        .fault_clear          (fault_clear),
        .decouple             (decouple),
        .oversize_error_clear (oversize_error_clear),
        .timeout_error_clear  (timeout_error_clear),
        .recovery_active      (recovery_active),
        .done_timeout_err     (done_timeout_err),
        .recovery_count       (recovery_count),
        .fsm_state            (fsm_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn            = 1'b0;
        sw_decouple        = 1'b0;
        auto_recover_en    = 1'b0;
        oversize_error_irq = 1'b0;
        timeout_error_irq  = 1'b0;
        decouple_done      = 1'b0;
        holdoff_cycles     = 16'd0;
        fault_clear        = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        do_reset();
        aresetn = 1'b0;
        #1;
        outs = {decouple, oversize_error_clear, timeout_error_clear, recovery_active,
                done_timeout_err, fsm_state, recovery_count};
        vec_cnt++;
        if (outs !== 24'd0) begin
            err_cnt++; $display("FAIL reset_outputs got=%h expected=%h", outs, 24'd0);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        sw_decouple = 1'b1;
        tick();
        vec_cnt++;
        if (decouple !== 1'b1 || fsm_state !== 3'd0) begin
            err_cnt++; $display("FAIL sw_decouple_idle got dec=%b st=%0d expected dec=1 st=0", decouple, fsm_state);
        end
        sw_decouple = 1'b0;
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        vec_cnt++;
        if (decouple !== 1'b0 || fsm_state !== 3'd0 || done_timeout_err !== 1'b0) begin
            err_cnt++; $display("FAIL idle_fault_clear got dec=%b st=%0d err=%b expected 0/0/0", decouple, fsm_state, done_timeout_err);
        end
    endtask

    task automatic test_basic_recovery();
        int n;
        int pulses;
        do_reset();
        holdoff_cycles = 16'd4;
        auto_recover_en = 1'b1;
        oversize_error_irq = 1'b1;
        tick();
        oversize_error_irq = 1'b0;
        vec_cnt++;
        if (fsm_state !== 3'd1 || decouple !== 1'b1 || recovery_active !== 1'b1) begin
            err_cnt++; $display("FAIL basic_decouple got st=%0d dec=%b act=%b expected 1/1/1", fsm_state, decouple, recovery_active);
        end
        tick();
        tick();
        decouple_done = 1'b1;
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd2 || oversize_error_clear !== 1'b1 || timeout_error_clear !== 1'b0) begin
            err_cnt++; $display("FAIL basic_clear got st=%0d ovc=%b toc=%b expected 2/1/0", fsm_state, oversize_error_clear, timeout_error_clear);
        end
        tick();
        n = 0;
        pulses = 0;
        while (fsm_state == 3'd3 && n < 20) begin
            if (oversize_error_clear || timeout_error_clear || !decouple) pulses++;
            n++;
            tick();
        end
        vec_cnt++;
        if (n !== 4 || pulses !== 0) begin
            err_cnt++; $display("FAIL basic_holdoff got cycles=%0d bad=%0d expected 4/0", n, pulses);
        end
        vec_cnt++;
        if (fsm_state !== 3'd4 || decouple !== 1'b0) begin
            err_cnt++; $display("FAIL basic_release got st=%0d dec=%b expected 4/0", fsm_state, decouple);
        end
        tick();
        decouple_done = 1'b0;
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd0 || recovery_count !== 16'd1 || recovery_active !== 1'b0) begin
            err_cnt++; $display("FAIL basic_done got st=%0d cnt=%0d act=%b expected 0/1/0", fsm_state, recovery_count, recovery_active);
        end
    endtask

    task automatic test_done_timeout();
        int n;
        do_reset();
        auto_recover_en = 1'b1;
        timeout_error_irq = 1'b1;
        tick();
        timeout_error_irq = 1'b0;
        n = 0;
        while (fsm_state == 3'd1 && n < 40) begin
            n++;
            tick();
        end
        vec_cnt++;
        if (n !== 15 || fsm_state !== 3'd5 || done_timeout_err !== 1'b1 || decouple !== 1'b1) begin
            err_cnt++; $display("FAIL dec_timeout got cycles=%0d st=%0d err=%b dec=%b expected 15/5/1/1", n, fsm_state, done_timeout_err, decouple);
        end
        decouple_done = 1'b1;
        oversize_error_irq = 1'b1;
        repeat (3) tick();
        vec_cnt++;
        if (fsm_state !== 3'd5 || decouple !== 1'b1 || oversize_error_clear !== 1'b0) begin
            err_cnt++; $display("FAIL fault_hold got st=%0d dec=%b ovc=%b expected 5/1/0", fsm_state, decouple, oversize_error_clear);
        end
        oversize_error_irq = 1'b0;
        decouple_done = 1'b0;
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        vec_cnt++;
        if (fsm_state !== 3'd0 || done_timeout_err !== 1'b0 || decouple !== 1'b0 || recovery_count !== 16'd0) begin
            err_cnt++; $display("FAIL fault_exit got st=%0d err=%b dec=%b cnt=%0d expected 0/0/0/0", fsm_state, done_timeout_err, decouple, recovery_count);
        end
    endtask

    task automatic test_retry();
        do_reset();
        holdoff_cycles = 16'd2;
        auto_recover_en = 1'b1;
        timeout_error_irq = 1'b1;
        tick();
        auto_recover_en = 1'b0;
        decouple_done = 1'b1;
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd2 || timeout_error_clear !== 1'b1 || oversize_error_clear !== 1'b0) begin
            err_cnt++; $display("FAIL retry_clear1 got st=%0d toc=%b ovc=%b expected 2/1/0", fsm_state, timeout_error_clear, oversize_error_clear);
        end
        tick();
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd3 || timeout_error_clear !== 1'b0) begin
            err_cnt++; $display("FAIL retry_holdoff got st=%0d toc=%b expected 3/0", fsm_state, timeout_error_clear);
        end
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd2 || timeout_error_clear !== 1'b1) begin
            err_cnt++; $display("FAIL retry_clear2 got st=%0d toc=%b expected 2/1", fsm_state, timeout_error_clear);
        end
        timeout_error_irq = 1'b0;
        tick();
        tick();
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd4) begin
            err_cnt++; $display("FAIL retry_release got st=%0d expected 4", fsm_state);
        end
        decouple_done = 1'b0;
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd0 || recovery_count !== 16'd1) begin
            err_cnt++; $display("FAIL retry_count got st=%0d cnt=%0d expected 0/1", fsm_state, recovery_count);
        end
    endtask

    task automatic test_sw_bypass();
        int dec_low;
        do_reset();
        holdoff_cycles = 16'd3;
        auto_recover_en = 1'b1;
        oversize_error_irq = 1'b1;
        tick();
        oversize_error_irq = 1'b0;
        decouple_done = 1'b1;
        tick();
        tick();
        sw_decouple = 1'b1;
        dec_low = 0;
        repeat (3) begin
            tick();
            if (decouple !== 1'b1) dec_low++;
        end
        vec_cnt++;
        if (fsm_state !== 3'd4) begin
            err_cnt++; $display("FAIL bypass_release got st=%0d expected 4", fsm_state);
        end
        tick();
        if (decouple !== 1'b1) dec_low++;
        vec_cnt++;
        if (fsm_state !== 3'd0 || recovery_count !== 16'd1 || dec_low !== 0) begin
            err_cnt++; $display("FAIL bypass_exit got st=%0d cnt=%0d declow=%0d expected 0/1/0", fsm_state, recovery_count, dec_low);
        end
        sw_decouple = 1'b0;
        decouple_done = 1'b0;
        tick();
        vec_cnt++;
        if (decouple !== 1'b0) begin
            err_cnt++; $display("FAIL bypass_drop got dec=%b expected 0", decouple);
        end
    endtask

    task automatic test_auto_disabled();
        int bad;
        do_reset();
        oversize_error_irq = 1'b1;
        timeout_error_irq = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            if (fsm_state !== 3'd0 || oversize_error_clear || timeout_error_clear || decouple) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++; $display("FAIL auto_off got bad_cycles=%0d expected 0", bad);
        end
        oversize_error_irq = 1'b0;
        timeout_error_irq = 1'b0;
    endtask

    task automatic test_holdoff_zero();
        do_reset();
        auto_recover_en = 1'b1;
        oversize_error_irq = 1'b1;
        tick();
        oversize_error_irq = 1'b0;
        decouple_done = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd3) begin
            err_cnt++; $display("FAIL hold0_enter got st=%0d expected 3", fsm_state);
        end
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd4) begin
            err_cnt++; $display("FAIL hold0_one_cycle got st=%0d expected 4", fsm_state);
        end
        decouple_done = 1'b0;
        tick();
    endtask

    task automatic test_release_timeout();
        int n;
        do_reset();
        holdoff_cycles = 16'd1;
        auto_recover_en = 1'b1;
        oversize_error_irq = 1'b1;
        tick();
        oversize_error_irq = 1'b0;
        decouple_done = 1'b1;
        tick();
        tick();
        tick();
        n = 0;
        while (fsm_state == 3'd4 && n < 40) begin
            n++;
            tick();
        end
        vec_cnt++;
        if (n !== 15 || fsm_state !== 3'd5 || done_timeout_err !== 1'b1 || recovery_count !== 16'd0) begin
            err_cnt++; $display("FAIL rel_timeout got cycles=%0d st=%0d err=%b cnt=%0d expected 15/5/1/0", n, fsm_state, done_timeout_err, recovery_count);
        end
        decouple_done = 1'b0;
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
    endtask

    task automatic test_reset_midseq();
        logic [23:0] outs;
        do_reset();
        auto_recover_en = 1'b1;
        oversize_error_irq = 1'b1;
        tick();
        oversize_error_irq = 1'b0;
        decouple_done = 1'b1;
        tick();
        tick();
        tick();
        decouple_done = 1'b0;
        tick();
        holdoff_cycles = 16'd10;
        oversize_error_irq = 1'b1;
        tick();
        oversize_error_irq = 1'b0;
        decouple_done = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd3 || recovery_count !== 16'd1) begin
            err_cnt++; $display("FAIL midseq_setup got st=%0d cnt=%0d expected 3/1", fsm_state, recovery_count);
        end
        #2;
        aresetn = 1'b0;
        #1;
        outs = {decouple, oversize_error_clear, timeout_error_clear, recovery_active,
                done_timeout_err, fsm_state, recovery_count};
        vec_cnt++;
        if (outs !== 24'd0) begin
            err_cnt++; $display("FAIL midseq_async got=%h expected=%h", outs, 24'd0);
        end
        auto_recover_en = 1'b0;
        decouple_done = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        vec_cnt++;
        if (fsm_state !== 3'd0 || oversize_error_clear !== 1'b0 || recovery_count !== 16'd0) begin
            err_cnt++; $display("FAIL midseq_restart got st=%0d ovc=%b cnt=%0d expected 0/0/0", fsm_state, oversize_error_clear, recovery_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_recovery();
        test_done_timeout();
        test_retry();
        test_sw_bypass();
        test_auto_disabled();
        test_holdoff_zero();
        test_release_timeout();
        test_reset_midseq();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
